// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-port arbiters.
package mem_pkg;
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int ADDR_STEP_DEF = 2;
endpackage

// File: rtl/rr_picker.sv
// Combinational one-hot winner selection: round-robin after last_winner,
// or fixed priority (lowest index) when RR_MODE is 0.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter bit RR_MODE = 1'b1,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] win
);
  logic [IDX_W:0]   slot;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    slot  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Round-robin visits last_winner+1 first and ends on last_winner itself.
      if (RR_MODE) begin
        slot = {1'b0, last_winner} + (IDX_W+1)'(i + 1);
        if (slot >= (IDX_W+1)'(NUM_REQ)) slot = slot - (IDX_W+1)'(NUM_REQ);
      end else begin
        slot = (IDX_W+1)'(i);
      end
      idx = slot[IDX_W-1:0];
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// Burst memory arbiter: hands the single memory port to one requester at a
// time for BURST_LEN consecutive-address beats.
module mem_arbiter_rr
  import mem_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int ADDR_STEP = ADDR_STEP_DEF,
  parameter bit RR_MODE   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        beat_ack,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic [BEAT_W-1:0]  beat;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic               last_beat;
  logic               beat_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .RR_MODE (RR_MODE),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req         (req),
    .last_winner (last_winner),
    .win         (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = IDX_W'(i);
  end

  // Beat handshake is combinational so the owner sees it in the mem_ack cycle.
  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
  assign beat_done = mem_en & mem_ack;
  assign beat_ack  = beat_done ? grant : '0;
  assign done      = (beat_done && last_beat) ? grant : '0;
  assign mem_addr  = mem_en ? base + ADDR_W'(beat) * ADDR_W'(ADDR_STEP) : '0;
  assign mem_wdata = mem_en ? wdata_arr[owner] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
      beat        <= '0;
      base        <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= BUSY;
            grant       <= pick;
            owner       <= pick_idx;
            last_winner <= pick_idx;
            base        <= addr_arr[pick_idx];
            beat        <= '0;
            mem_en      <= 1'b1;
            mem_wr      <= we[pick_idx];
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata <= mem_rdata;
            // Dropping to IDLE here forces the one-cycle gap before the next grant.
            if (last_beat) begin
              state  <= IDLE;
              grant  <= '0;
              mem_en <= 1'b0;
              mem_wr <= 1'b0;
              beat   <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr (round-robin instance) plus a
// fixed-priority instance exercised for starvation.
module tb_mem_arbiter_rr;
  localparam int NUM_REQ   = 2;
  localparam int BURST_LEN = 4;
  localparam int ADDR_STEP = 2;

  typedef struct {
    int          owner;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wd;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, r_we;
  logic [31:0] addr, wdata;
  logic [1:0]  grant, beat_ack, done;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_ack;

  logic [1:0]  req_fp, grant_fp, beat_ack_fp, done_fp;
  logic [15:0] rdata_fp, mem_addr_fp, mem_wdata_fp;
  logic        mem_en_fp, mem_wr_fp, mem_ack_fp;

  logic [15:0] r_addr [2];
  logic [15:0] r_w0 [2];
  logic [15:0] ack_cnt [2];
  logic [1:0]  adv;
  logic [15:0] rd_exp;
  logic        mem_auto, spur;
  int          lat;
  int          exp_last;
  exp_t        exp_q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign addr      = {r_addr[1], r_addr[0]};
  assign wdata     = {r_w0[1] + ack_cnt[1], r_w0[0] + ack_cnt[0]};
  assign mem_rdata = mem_addr ^ 16'hA5C3;

  mem_arbiter_rr #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .BURST_LEN(BURST_LEN),
                   .ADDR_STEP(ADDR_STEP), .RR_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(r_we), .addr(addr), .wdata(wdata),
    .grant(grant), .beat_ack(beat_ack), .done(done), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  mem_arbiter_rr #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .BURST_LEN(BURST_LEN),
                   .ADDR_STEP(ADDR_STEP), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req(req_fp), .we(2'b00), .addr({16'h7100, 16'h7000}),
    .wdata(32'h0), .grant(grant_fp), .beat_ack(beat_ack_fp), .done(done_fp),
    .rdata(rdata_fp), .mem_en(mem_en_fp), .mem_wr(mem_wr_fp), .mem_addr(mem_addr_fp),
    .mem_wdata(mem_wdata_fp), .mem_rdata(16'h0), .mem_ack(mem_ack_fp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  function automatic int predict(input logic [1:0] mask);
    int j;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (exp_last + i) % NUM_REQ;
      if (mask[j]) return j;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    r_we[i]   = w;
    r_addr[i] = a;
    r_w0[i]   = d;
  endtask

  task automatic push_burst(input int w);
    exp_t e;
    for (int k = 0; k < BURST_LEN; k++) begin
      e.owner = w;
      e.addr  = r_addr[w] + 16'(k * ADDR_STEP);
      e.we    = r_we[w];
      e.wd    = r_w0[w] + ack_cnt[w] + 16'(k);
      e.last  = (k == BURST_LEN - 1);
      exp_q.push_back(e);
    end
    exp_last = w;
  endtask

  // Called just after a negedge with the DUT idle; returns at the grant negedge.
  task automatic issue(input logic [1:0] mask);
    int w;
    w = predict(mask);
    push_burst(w);
    req = mask;
    @(negedge clk);
    chk("grant_lat", grant, 32'(1 << w));
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (|done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  // Memory model and requester data advance, driven just after each posedge.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_ack_fp = 1'b0;
    ack_cnt[0] = '0;
    ack_cnt[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (adv[i]) ack_cnt[i] = ack_cnt[i] + 16'd1;
      if (!mem_auto) mem_ack = spur;
      else if (mem_ack) mem_ack = 1'b0;
      else if (mem_en) begin
        if (cnt >= lat) begin mem_ack = 1'b1; cnt = 0; end
        else cnt++;
      end else cnt = 0;
      mem_ack_fp = mem_en_fp && !mem_ack_fp;
    end
  end

  // Output monitor: pops the scoreboard on every beat_ack.
  initial begin
    exp_t e;
    logic rd_pend, prev_done;
    rd_pend = 1'b0;
    prev_done = 1'b0;
    adv = '0;
    rd_exp = '0;
    forever begin
      @(negedge clk);
      if (rd_pend) chk("rdata", rdata, rd_exp);
      rd_pend = 1'b0;
      chk("en_vs_grant", mem_en, |grant);
      if (grant == 2'b00) chk("idle_addr", mem_addr, 0);
      if (prev_done) chk("bubble", grant, 0);
      if (|beat_ack) begin
        if (exp_q.size() == 0) chk("unexp_ack", beat_ack, 0);
        else begin
          e = exp_q.pop_front();
          chk("ack_owner", beat_ack, 32'(1 << e.owner));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wr", mem_wr, e.we);
          chk("done", done, e.last ? 32'(1 << e.owner) : 0);
          if (e.we) chk("mem_wdata", mem_wdata, e.wd);
          else begin
            rd_pend = 1'b1;
            rd_exp  = e.addr ^ 16'hA5C3;
          end
        end
      end else if (|done) chk("done_no_ack", done, 0);
      adv = beat_ack;
      prev_done = |done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int nb, acks;
    logic [1:0] prev;
    rst = 1'b0; req = '0; req_fp = '0; r_we = '0;
    r_addr[0] = '0; r_addr[1] = '0; r_w0[0] = '0; r_w0[1] = '0;
    mem_auto = 1'b1; spur = 1'b0; lat = 1; exp_last = NUM_REQ - 1;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single read burst from requester 1.
    set_req(1, 1'b0, 16'h0100, 16'h0000);
    issue(2'b10);
    req = '0;
    wait_done();
    repeat (2) @(negedge clk);

    // Write burst wrapping the top of the address space.
    lat = 0;
    set_req(0, 1'b1, 16'hFFFC, 16'h1230);
    issue(2'b01);
    chk("wr_level", mem_wr, 1);
    req = '0;
    wait_done();
    repeat (2) @(negedge clk);

    // Round-robin contention with both requests held.
    lat = 2;
    set_req(0, 1'b0, 16'h2000, 16'h0000);
    set_req(1, 1'b0, 16'h3000, 16'h0000);
    for (int b = 0; b < 4; b++) push_burst(predict(2'b11));
    req = 2'b11;
    for (int b = 0; b < 4; b++) wait_done();
    req = '0;
    repeat (3) @(negedge clk);

    // Fixed-priority contention: requester 1 must never win.
    req_fp = 2'b11;
    nb = 0;
    prev = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (grant_fp != 2'b00 && prev == 2'b00) begin
        nb++;
        chk("fp_grant", grant_fp, 2'b01);
        chk("fp_addr", mem_addr_fp, 16'h7000);
      end
      prev = grant_fp;
    end
    req_fp = '0;
    chk("fp_bursts", nb >= 4, 1);
    repeat (12) @(negedge clk);

    // mem_ack while idle is ignored.
    mem_auto = 1'b0;
    spur = 1'b1;
    @(negedge clk);
    chk("spur_ack", beat_ack, 0);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_rdata", rdata, rd_exp);
    chk("spur_grant", grant, 0);
    mem_auto = 1'b1;
    lat = 1;

    // New request raised in the done cycle waits for the idle cycle.
    set_req(0, 1'b0, 16'h4000, 16'h0000);
    set_req(1, 1'b0, 16'h5000, 16'h0000);
    issue(2'b01);
    req = '0;
    wait_done();
    push_burst(predict(2'b10));
    req = 2'b10;
    @(negedge clk);
    chk("late_gap", grant, 0);
    @(negedge clk);
    chk("late_grant", grant, 2'b10);
    req = '0;
    wait_done();
    repeat (3) @(negedge clk);

    // Asynchronous reset after the second beat of a write burst.
    set_req(1, 1'b1, 16'h6000, 16'h0600);
    issue(2'b10);
    req = '0;
    acks = 0;
    for (int n = 0; n < 200 && acks < 2; n++) begin
      @(negedge clk);
      if (|beat_ack) acks++;
    end
    chk("rst_acks", acks, 2);
    mem_auto = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_ack", beat_ack, 0);
    chk("arst_done", done, 0);
    chk("arst_en", mem_en, 0);
    chk("arst_wr", mem_wr, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_rdata", rdata, 0);
    exp_q.delete();
    exp_last = NUM_REQ - 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_auto = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 16'h0800, 16'h0000);
    set_req(1, 1'b0, 16'h0900, 16'h0000);
    issue(2'b11);
    req = '0;
    wait_done();
    repeat (3) @(negedge clk);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
